// File: rtl/dsky_key_scanner_pkg.sv
// dsky_key_scanner_pkg: shared key codes, FSM states and frame candidate type
package dsky_key_scanner_pkg;
  `include "dsky_keycodes.vh"
  typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;
  typedef struct packed {
    logic       multi;
    logic [4:0] code;
  } cand_t;
endpackage

// File: rtl/dsky_key_debounce.sv
// dsky_key_debounce: run-length detector flagging a value seen on N consecutive enables
module dsky_key_debounce #(
  parameter int W = 6,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         stable
);
  localparam int CW = $clog2(N + 1);
  logic [W-1:0]  prev;
  logic [CW-1:0] run, run_nxt;
  // stable reflects the value being presented now, so callers act in the same cycle
  always_comb run_nxt = (din == prev) ? ((run == CW'(N)) ? run : run + CW'(1)) : CW'(1);
  assign stable = run_nxt == CW'(N);
  // remember the last value and its run length on each enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= '0;
      run  <= '0;
    end else if (en) begin
      prev <= din;
      run  <= run_nxt;
    end
endmodule

// File: rtl/dsky_keycodes.vh
// dsky_keycodes: DSKY key codes (octal) and the 4x5 matrix position-to-code table
`ifndef DSKY_KEYCODES_VH
`define DSKY_KEYCODES_VH
localparam logic [4:0] KEY_NONE   = 5'o00;
localparam logic [4:0] KEY_0      = 5'o20;
localparam logic [4:0] KEY_1      = 5'o01;
localparam logic [4:0] KEY_2      = 5'o02;
localparam logic [4:0] KEY_3      = 5'o03;
localparam logic [4:0] KEY_4      = 5'o04;
localparam logic [4:0] KEY_5      = 5'o05;
localparam logic [4:0] KEY_6      = 5'o06;
localparam logic [4:0] KEY_7      = 5'o07;
localparam logic [4:0] KEY_8      = 5'o10;
localparam logic [4:0] KEY_9      = 5'o11;
localparam logic [4:0] KEY_VERB   = 5'o21;
localparam logic [4:0] KEY_NOUN   = 5'o37;
localparam logic [4:0] KEY_PLUS   = 5'o32;
localparam logic [4:0] KEY_MINUS  = 5'o33;
localparam logic [4:0] KEY_CLR    = 5'o36;
localparam logic [4:0] KEY_KEYREL = 5'o31;
localparam logic [4:0] KEY_ENTR   = 5'o34;
localparam logic [4:0] KEY_RSET   = 5'o22;
// Position index is row*5+col; PRO and the unused slot carry no code.
localparam logic [4:0] POS_PRO    = 5'd9;
localparam logic [4:0] POS_UNUSED = 5'd19;
localparam logic [0:19][4:0] KEY_MAP = {
  KEY_VERB, KEY_NOUN, KEY_PLUS, KEY_MINUS,  KEY_0,
  KEY_7,    KEY_8,    KEY_9,    KEY_CLR,    KEY_NONE,
  KEY_4,    KEY_5,    KEY_6,    KEY_KEYREL, KEY_ENTR,
  KEY_1,    KEY_2,    KEY_3,    KEY_RSET,   KEY_NONE
};
`endif

// File: rtl/dsky_key_scanner.sv
// dsky_key_scanner: scans and debounces the 4x5 DSKY matrix, drives MKEY1..5, PROCEED, KEY_STROBE
module dsky_key_scanner
  import dsky_key_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 512,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic [3:0] ROW_n,
  output logic [4:0] COL_n,
  output logic       MKEY1,
  output logic       MKEY2,
  output logic       MKEY3,
  output logic       MKEY4,
  output logic       MKEY5,
  output logic       PROCEED,
  output logic       KEY_STROBE
);
  localparam int DW = $clog2(SCAN_DIV);
  logic          run;
  logic [DW-1:0] div_cnt;
  logic [2:0]    col;
  logic [3:0]    row_m, row_s;
  logic          slot_end, frame_end;
  logic [4:0]    row_code [4];
  logic [3:0]    row_pro;
  logic [2:0]    col_cnt, tot;
  logic [4:0]    col_code, code_any;
  logic [1:0]    acc_n;
  logic [4:0]    acc_code;
  logic          acc_pro, pro_f;
  cand_t         cand;
  logic          key_stable, pro_stable;
  state_t        state, state_nxt;
  logic [4:0]    mkey, mkey_nxt;
  logic          strobe_nxt;

  assign slot_end  = run && div_cnt == DW'(SCAN_DIV - 1);
  assign frame_end = slot_end && col == 3'd4;

  // column sequencer: idle-high in reset, column 0 on the first clock, then rotate every slot
  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) begin
      run     <= 1'b0;
      div_cnt <= '0;
      col     <= '0;
      COL_n   <= 5'b11111;
    end else if (!run) begin
      run   <= 1'b1;
      COL_n <= 5'b11110;
    end else if (slot_end) begin
      div_cnt <= '0;
      col     <= (col == 3'd4) ? 3'd0 : col + 3'd1;
      COL_n   <= {COL_n[3:0], COL_n[4]};
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end

  // two-stage synchronizer for the asynchronous row lines
  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) {row_s, row_m} <= 8'hFF;
    else          {row_s, row_m} <= {row_m, ROW_n};

  for (genvar g = 0; g < 4; g++) begin : g_row
    logic [4:0] idx;
    assign idx         = 5'(g * 5) + {2'b00, col};
    assign row_code[g] = (row_s[g] || idx == POS_PRO || idx == POS_UNUSED) ? KEY_NONE : KEY_MAP[idx];
    assign row_pro[g]  = !row_s[g] && idx == POS_PRO;
  end

  // with exactly one coded key in a column the OR of row codes is that code
  assign col_cnt  = 3'(|row_code[0]) + 3'(|row_code[1]) + 3'(|row_code[2]) + 3'(|row_code[3]);
  assign col_code = row_code[0] | row_code[1] | row_code[2] | row_code[3];
  assign tot      = {1'b0, acc_n} + col_cnt;
  assign code_any = (acc_n == 2'd0) ? col_code : acc_code;
  assign pro_f    = acc_pro | col_pro_any();
  assign cand     = '{multi: tot > 3'd1, code: (tot == 3'd1) ? code_any : KEY_NONE};

  function automatic logic col_pro_any();
    return |row_pro;
  endfunction

  // accumulate key count (saturating at 2), code and PRO across the frame
  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) begin
      acc_n    <= '0;
      acc_code <= '0;
      acc_pro  <= 1'b0;
    end else if (slot_end) begin
      acc_n    <= frame_end ? 2'd0 : (tot > 3'd1) ? 2'd2 : tot[1:0];
      acc_code <= frame_end ? 5'd0 : code_any;
      acc_pro  <= !frame_end && pro_f;
    end

  dsky_key_debounce #(.W($bits(cand_t)), .N(DEBOUNCE_SCANS)) u_key_db (
    .clk(SIM_CLK), .rst_n(SIM_RST), .en(frame_end), .din(cand), .stable(key_stable)
  );

  dsky_key_debounce #(.W(1), .N(DEBOUNCE_SCANS)) u_pro_db (
    .clk(SIM_CLK), .rst_n(SIM_RST), .en(frame_end), .din(pro_f), .stable(pro_stable)
  );

  // FSM state register
  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) state <= IDLE;
    else          state <= state_nxt;

  // next state: only stable frame-end candidates move the FSM; a new key needs a stable release first
  always_comb
    state_nxt = !(frame_end && key_stable) ? state :
                (state == IDLE) ? ((!cand.multi && cand.code != KEY_NONE) ? PRESSED : IDLE) :
                (cand == '0) ? IDLE :
                (state == PRESSED && !cand.multi && cand.code == mkey) ? PRESSED : LOCKOUT;

  // outputs: code only while PRESSED, strobe only on acceptance
  always_comb begin
    mkey_nxt   = (state_nxt == PRESSED) ? ((state == PRESSED) ? mkey : cand.code) : KEY_NONE;
    strobe_nxt = state == IDLE && state_nxt == PRESSED;
  end

  // registered outputs; PROCEED follows its own debounced level
  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) begin
      mkey       <= '0;
      KEY_STROBE <= 1'b0;
      PROCEED    <= 1'b0;
    end else begin
      mkey       <= mkey_nxt;
      KEY_STROBE <= strobe_nxt;
      PROCEED    <= (frame_end && pro_stable) ? pro_f : PROCEED;
    end

  assign {MKEY5, MKEY4, MKEY3, MKEY2, MKEY1} = mkey;
endmodule

// File: tb/tb_dsky_key_scanner.sv
// tb_dsky_key_scanner: frame-table and reset-sequence checks of the DSKY key scanner
module tb_dsky_key_scanner;
  localparam logic [19:0] P_VERB = 20'd1 << 0;
  localparam logic [19:0] P_NOUN = 20'd1 << 1;
  localparam logic [19:0] P_7    = 20'd1 << 5;
  localparam logic [19:0] P_PRO  = 20'd1 << 9;
  localparam logic [19:0] P_5    = 20'd1 << 11;
  localparam logic [19:0] P_6    = 20'd1 << 12;
  localparam logic [19:0] P_ENTR = 20'd1 << 14;
  localparam logic [19:0] P_1    = 20'd1 << 15;
  localparam logic [19:0] P_2    = 20'd1 << 16;
  localparam logic [19:0] P_UNU  = 20'd1 << 19;

  typedef struct {
    logic [19:0] keys;
    logic [4:0]  mkey;
    logic        pro;
    logic        stb;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0, row_force = 1'b0;
  logic [19:0] keys = '0;
  logic [3:0]  row_n;
  logic [4:0]  col_n, mkey, ec;
  logic        mk1, mk2, mk3, mk4, mk5, proceed, strobe;
  int          n_chk = 0, n_fail = 0, n_strobe = 0;
  vec_t        tv[$];

  dsky_key_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .ROW_n(row_n), .COL_n(col_n),
    .MKEY1(mk1), .MKEY2(mk2), .MKEY3(mk3), .MKEY4(mk4), .MKEY5(mk5),
    .PROCEED(proceed), .KEY_STROBE(strobe)
  );

  assign mkey = {mk5, mk4, mk3, mk2, mk1};

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = row_force ? 1'b0 : ~|(keys[r*5 +: 5] & ~col_n);
  end

  always @(negedge clk) if (strobe) n_strobe++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [19:0] k, input logic [4:0] m, input logic p, input logic s);
    tv.push_back('{keys: k, mkey: m, pro: p, stb: s});
  endtask

  task automatic frame(input string tag, input logic [19:0] k, input logic [4:0] m, input logic p, input logic s);
    keys = k;
    repeat (20) @(posedge clk);
    #1;
    check({tag, " mkey"}, 32'(mkey), 32'(m));
    check({tag, " proceed"}, 32'(proceed), 32'(p));
    check({tag, " strobe"}, 32'(strobe), 32'(s));
    check({tag, " col"}, 32'(col_n), 32'h1E);
  endtask

  initial begin
    add(P_ENTR, 0, 0, 0); add(P_ENTR, 0, 0, 0); add(P_ENTR, 5'o34, 0, 1);
    add(P_ENTR, 5'o34, 0, 0); add(P_ENTR, 5'o34, 0, 0);
    add(0, 5'o34, 0, 0); add(0, 5'o34, 0, 0); add(0, 0, 0, 0);
    add(P_7, 0, 0, 0); add(0, 0, 0, 0); add(P_7, 0, 0, 0); add(0, 0, 0, 0);
    add(P_7, 0, 0, 0); add(P_7, 0, 0, 0); add(P_7, 5'o07, 0, 1); add(P_7, 5'o07, 0, 0);
    add(0, 5'o07, 0, 0); add(0, 5'o07, 0, 0); add(0, 0, 0, 0);
    add(P_5, 0, 0, 0); add(P_5, 0, 0, 0); add(P_5, 5'o05, 0, 1);
    add(P_5 | P_6, 5'o05, 0, 0); add(P_5 | P_6, 5'o05, 0, 0); add(P_5 | P_6, 0, 0, 0);
    add(P_6, 0, 0, 0); add(P_6, 0, 0, 0); add(P_6, 0, 0, 0);
    add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
    add(P_6, 0, 0, 0); add(P_6, 0, 0, 0); add(P_6, 5'o06, 0, 1);
    add(0, 5'o06, 0, 0); add(0, 5'o06, 0, 0); add(0, 0, 0, 0);
    add(P_PRO | P_1 | P_2 | P_UNU, 0, 0, 0); add(P_PRO | P_1 | P_2 | P_UNU, 0, 0, 0);
    add(P_PRO | P_1 | P_2 | P_UNU, 0, 1, 0);
    add(P_UNU, 0, 1, 0); add(P_UNU, 0, 1, 0); add(P_UNU, 0, 0, 0);
    add(P_NOUN | P_PRO, 0, 0, 0); add(P_NOUN | P_PRO, 0, 0, 0); add(P_NOUN | P_PRO, 5'o37, 1, 1);
    add(P_NOUN, 5'o37, 1, 0); add(P_NOUN, 5'o37, 1, 0); add(P_NOUN, 5'o37, 0, 0);
    add(0, 5'o37, 0, 0); add(0, 5'o37, 0, 0); add(0, 0, 0, 0);
    add(P_VERB, 0, 0, 0); add(P_VERB, 0, 0, 0); add(P_VERB, 5'o21, 0, 1); add(P_VERB, 5'o21, 0, 0);

    row_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst col", 32'(col_n), 32'h1F);
    check("rst mkey", 32'(mkey), 0);
    check("rst proceed", 32'(proceed), 0);
    check("rst strobe", 32'(strobe), 0);
    @(negedge clk);
    row_force = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j <= 20; j++) begin
      ec = ~(5'd1 << ((j / 4) % 5));
      check($sformatf("scan col c%0d", j), 32'(col_n), 32'(ec));
      if (j < 20) begin
        @(posedge clk);
        #1;
      end
    end
    check("idle mkey", 32'(mkey), 0);

    for (int i = 0; i < tv.size(); i++)
      frame($sformatf("v%0d", i), tv[i].keys, tv[i].mkey, tv[i].pro, tv[i].stb);

    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst mkey", 32'(mkey), 0);
    check("midrst col", 32'(col_n), 32'h1F);
    check("midrst strobe", 32'(strobe), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerun col", 32'(col_n), 32'h1E);
    check("rerun strobe", 32'(strobe), 0);
    frame("rr0", P_VERB, 0, 0, 0);
    frame("rr1", P_VERB, 0, 0, 0);
    frame("rr2", P_VERB, 5'o21, 0, 1);
    frame("rr3", P_VERB, 5'o21, 0, 0);
    repeat (2) @(negedge clk);
    check("strobe total", 32'(n_strobe), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
